// File: rtl/reg_array_p_if.sv
//==============================================================================
// Module      : reg_array_p_if
// Description : Bus bundle for reg_array_p: write sources, load/read controls,
//               clear request, read data and status outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface reg_array_p_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
);
    logic [DATA_W-1:0]          data_in;
    logic [DATA_W-1:0]          alu_in;
    logic                       sel_alu;
    logic                       load_r0;
    logic                       load_rn;
    logic [SEL_W-1:0]           rn_sel;
    logic                       en_r0;
    logic                       en_rn;
    logic                       clr_req;
    logic [DATA_W-1:0]          data_out;
    logic                       data_valid;
    logic [DATA_W-1:0]          r0_out;
    logic                       busy;
    logic                       wr_conflict;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;

    modport master (
        output data_in, alu_in, sel_alu, load_r0, load_rn, rn_sel,
               en_r0, en_rn, clr_req,
        input  data_out, data_valid, r0_out, busy, wr_conflict, regs_flat
    );

    modport slave (
        input  data_in, alu_in, sel_alu, load_r0, load_rn, rn_sel,
               en_r0, en_rn, clr_req,
        output data_out, data_valid, r0_out, busy, wr_conflict, regs_flat
    );
endinterface

`default_nettype wire

// File: rtl/reg_array_p.sv
//==============================================================================
// Module      : reg_array_p
// Description : Parametrised register array with accumulator R0, registered
//               read port with write/clear bypass, and a sequenced clear sweep.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_array_p #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
) (
    input  logic          clk1,
    input  logic          rst_n,
    reg_array_p_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] C_LAST_IDX = SEL_W'(NUM_REGS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [SEL_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_regs [NUM_REGS];
    logic [DATA_W-1:0]  r_data_out;
    logic               r_data_valid;
    logic               r_wr_conflict;

    logic [DATA_W-1:0]  w_wv;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_wr_ok;
    logic               w_wr_en;
    logic               w_clr_en;
    logic               w_last;
    logic               w_rd_en;
    logic [SEL_W-1:0]   w_wr_idx;
    logic [SEL_W-1:0]   w_rd_idx;

    assign w_wv     = bus.sel_alu ? bus.alu_in : bus.data_in;
    // Loads are only honoured in IDLE and lose to a clear request.
    assign w_wr_ok  = (r_state == IDLE) && !bus.clr_req;
    assign w_wr_en  = w_wr_ok && (bus.load_r0 || bus.load_rn);
    assign w_wr_idx = bus.load_r0 ? '0 : bus.rn_sel;
    assign w_clr_en = (r_state == CLEAR);
    assign w_last   = (r_idx == C_LAST_IDX);
    assign w_rd_en  = bus.en_r0 || bus.en_rn;
    assign w_rd_idx = bus.en_r0 ? '0 : bus.rn_sel;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.clr_req) w_state_next = CLEAR;
            CLEAR:   if (w_last)      w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= (w_clr_en && !w_last) ? r_idx + 1'b1 : '0;
        end
    end

    // Out-of-range indices match no register, so such reads return 0
    // and such writes are dropped without extra decode.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_rd_idx == SEL_W'(k)) begin
                if (w_clr_en && (r_idx == SEL_W'(k)))
                    w_rd_data = '0;
                else if (w_wr_en && (w_wr_idx == SEL_W'(k)))
                    w_rd_data = w_wv;
                else
                    w_rd_data = r_regs[k];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_clr_en && (r_idx == SEL_W'(k)))
                    r_regs[k] <= '0;
                else if (w_wr_en && (w_wr_idx == SEL_W'(k)))
                    r_regs[k] <= w_wv;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_wr_conflict <= 1'b0;
        end else begin
            if (w_rd_en) r_data_out <= w_rd_data;
            r_data_valid  <= w_rd_en;
            r_wr_conflict <= w_wr_ok && bus.load_r0 && bus.load_rn;
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.data_valid  = r_data_valid;
    assign bus.r0_out      = r_regs[0];
    assign bus.busy        = (r_state == CLEAR);
    assign bus.wr_conflict = r_wr_conflict;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
            assign bus.regs_flat[i*DATA_W +: DATA_W] = r_regs[i];
        end
    endgenerate

endmodule

`default_nettype wire
